ex_unit: RTL and testbench

Execute stage of the pipeline: consumes the operation, operands and writeback tags produced by the ID/EX pipeline register. It computes single-cycle ALU results in one clock and iterative multiply/divide in 32 iterations. While an iterative operation runs, it stalls the upstream IF/ID and ID/EX registers. Results and writeback tags are registered here and handed to the EX/MEM register.

---
 rtl/ex_unit.sv | 182 ++++++++++++++++++
 tb/tb_ex_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_unit.sv
// ex_unit: execute stage, 1-cycle ALU plus 32-iteration shift-add multiply.
// Restoring divide/remainder is built only when EX_DIV_EN is defined.
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
`ifndef ALU_TYPE_WIDTH
`define ALU_TYPE_WIDTH 5
`endif
`ifndef REG_NUM
`define REG_NUM 5
`endif
`ifndef ALU_NOP
`define ALU_NOP   5'd0
`define ALU_ADD   5'd1
`define ALU_SUB   5'd2
`define ALU_AND   5'd3
`define ALU_OR    5'd4
`define ALU_XOR   5'd5
`define ALU_SLL   5'd6
`define ALU_SRL   5'd7
`define ALU_SRA   5'd8
`define ALU_SLT   5'd9
`define ALU_SLTU  5'd10
`define ALU_MUL   5'd11
`define ALU_MULHU 5'd12
`define ALU_DIV   5'd13
`define ALU_DIVU  5'd14
`define ALU_REM   5'd15
`define ALU_REMU  5'd16
`endif

module ex_unit (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`ALU_TYPE_WIDTH-1:0] alu_type,
    input  logic [`COMMON_WIDTH-1:0]   src1,
    input  logic [`COMMON_WIDTH-1:0]   src2,
    input  logic [`REG_NUM-1:0]        reg_write,
    input  logic                       write_alu_result_tag,
    input  logic                       flush,
    output logic [`COMMON_WIDTH-1:0]   result,
    output logic [`REG_NUM-1:0]        reg_write_out,
    output logic                       write_alu_result_tag_out,
    output logic                       stall,
    output logic                       illegal_op
);
    localparam int W = `COMMON_WIDTH;
`ifdef EX_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif
    state_t state, state_nx;
    logic [5:0] cnt;
    logic [`ALU_TYPE_WIDTH-1:0] op;
    logic [`REG_NUM-1:0] dst;
    logic tag, alu_ok, is_mul, is_div, ill, done;
    logic [W-1:0] m, hi, lo, hi_nx, lo_nx, fin, alu_res, cap_m, cap_lo;
    logic [W:0] msum;
    logic [4:0] sh;

    assign sh     = src2[4:0];
    assign done   = cnt == 6'd31;
    assign stall  = state != IDLE;
    assign is_mul = alu_type == `ALU_MUL || alu_type == `ALU_MULHU;
    assign ill    = !alu_ok && !is_mul && !is_div && alu_type != `ALU_NOP;
    // hi accumulates, lo holds the multiplier shifting right into the low product word
    assign msum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        case (alu_type)
            `ALU_ADD:  alu_res = src1 + src2;
            `ALU_SUB:  alu_res = src1 - src2;
            `ALU_AND:  alu_res = src1 & src2;
            `ALU_OR:   alu_res = src1 | src2;
            `ALU_XOR:  alu_res = src1 ^ src2;
            `ALU_SLL:  alu_res = src1 << sh;
            `ALU_SRL:  alu_res = src1 >> sh;
            `ALU_SRA:  alu_res = $signed(src1) >>> sh;
            `ALU_SLT:  alu_res = {{(W-1){1'b0}}, $signed(src1) < $signed(src2)};
            `ALU_SLTU: alu_res = {{(W-1){1'b0}}, src1 < src2};
            default:   alu_ok  = 1'b0;
        endcase
    end

`ifdef EX_DIV_EN
    logic [W-1:0] a, dif, q, r, v;
    logic [W:0] t;
    logic s2, ge, rem_op, neg, sgn_in;
    assign is_div = alu_type == `ALU_DIV || alu_type == `ALU_DIVU || alu_type == `ALU_REM || alu_type == `ALU_REMU;
    assign sgn_in = alu_type == `ALU_DIV || alu_type == `ALU_REM;
    assign cap_m  = is_div ? (sgn_in && src2[W-1] ? -src2 : src2) : src1;
    assign cap_lo = is_div ? (sgn_in && src1[W-1] ? -src1 : src1) : src2;
    // hi is the partial remainder, lo shifts the dividend out and quotient bits in
    assign t      = {hi, lo[W-1]};
    assign ge     = t >= {1'b0, m};
    assign dif    = t[W-1:0] - m;
    assign r      = ge ? dif : t[W-1:0];
    assign q      = {lo[W-2:0], ge};
    assign rem_op = op == `ALU_REM || op == `ALU_REMU;
    assign neg    = (op == `ALU_DIV || op == `ALU_REM) && (rem_op ? a[W-1] : a[W-1] ^ s2);
    assign v      = rem_op ? r : q;
    assign hi_nx  = state == DIV ? r : msum[W:1];
    assign lo_nx  = state == DIV ? q : {msum[0], lo[W-1:1]};
    assign fin    = state == DIV ? (m == '0 ? (rem_op ? a : '1) : (neg ? -v : v))
                                 : (op == `ALU_MULHU ? hi_nx : lo_nx);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a  <= '0;
            s2 <= 1'b0;
        end else if (state == IDLE) begin
            a  <= src1;
            s2 <= src2[W-1];
        end
    end
`else
    assign is_div = 1'b0;
    assign cap_m  = src1;
    assign cap_lo = src2;
    assign hi_nx  = msum[W:1];
    assign lo_nx  = {msum[0], lo[W-1:1]};
    assign fin    = op == `ALU_MULHU ? hi_nx : lo_nx;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) state_nx = IDLE;
`ifdef EX_DIV_EN
        else if (state == IDLE && is_div) state_nx = DIV;
`endif
        else if (state == IDLE && is_mul) state_nx = MUL;
        else if (state != IDLE && done) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt                      <= '0;
            op                       <= '0;
            dst                      <= '0;
            tag                      <= 1'b0;
            m                        <= '0;
            hi                       <= '0;
            lo                       <= '0;
            result                   <= '0;
            reg_write_out            <= '0;
            write_alu_result_tag_out <= 1'b0;
            illegal_op               <= 1'b0;
        end else if (flush) begin
            cnt                      <= '0;
            reg_write_out            <= '0;
            write_alu_result_tag_out <= 1'b0;
            illegal_op               <= 1'b0;
        end else if (state == IDLE) begin
            cnt                      <= '0;
            hi                       <= '0;
            m                        <= cap_m;
            lo                       <= cap_lo;
            op                       <= alu_type;
            dst                      <= reg_write;
            tag                      <= write_alu_result_tag;
            result                   <= alu_ok ? alu_res : (ill ? '0 : result);
            reg_write_out            <= alu_ok ? reg_write : '0;
            write_alu_result_tag_out <= alu_ok && write_alu_result_tag;
            illegal_op               <= ill;
        end else begin
            cnt                      <= cnt + 6'd1;
            hi                       <= hi_nx;
            lo                       <= lo_nx;
            reg_write_out            <= done ? dst : '0;
            write_alu_result_tag_out <= done && tag;
            illegal_op               <= 1'b0;
            if (done) result <= fin;
        end
    end
endmodule

// File: tb/tb_ex_unit.sv
// tb_ex_unit: table-driven single-cycle vectors plus directed multiply/divide,
// flush and mid-operation reset sequences for ex_unit.
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
`ifndef ALU_TYPE_WIDTH
`define ALU_TYPE_WIDTH 5
`endif
`ifndef REG_NUM
`define REG_NUM 5
`endif
`ifndef ALU_NOP
`define ALU_NOP   5'd0
`define ALU_ADD   5'd1
`define ALU_SUB   5'd2
`define ALU_AND   5'd3
`define ALU_OR    5'd4
`define ALU_XOR   5'd5
`define ALU_SLL   5'd6
`define ALU_SRL   5'd7
`define ALU_SRA   5'd8
`define ALU_SLT   5'd9
`define ALU_SLTU  5'd10
`define ALU_MUL   5'd11
`define ALU_MULHU 5'd12
`define ALU_DIV   5'd13
`define ALU_DIVU  5'd14
`define ALU_REM   5'd15
`define ALU_REMU  5'd16
`endif

module tb_ex_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  alu_type = `ALU_NOP;
    logic [31:0] src1 = '0, src2 = '0;
    logic [4:0]  reg_write = '0;
    logic        write_alu_result_tag = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] result;
    logic [4:0]  reg_write_out;
    logic        write_alu_result_tag_out, stall, illegal_op;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic        tg;
        logic [31:0] er;
        logic [4:0]  erd;
        logic        etg, eill;
    } vec_t;
    vec_t vq[$];

    always #5 clk = ~clk;

    ex_unit dut (
        .clk(clk), .rst(rst), .alu_type(alu_type), .src1(src1), .src2(src2),
        .reg_write(reg_write), .write_alu_result_tag(write_alu_result_tag), .flush(flush),
        .result(result), .reg_write_out(reg_write_out),
        .write_alu_result_tag_out(write_alu_result_tag_out), .stall(stall), .illegal_op(illegal_op)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] o, input logic [31:0] a, b, input logic [4:0] rd, input logic tg);
        alu_type = o; src1 = a; src2 = b; reg_write = rd; write_alu_result_tag = tg;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // op captured at E0, result after E32, held ADD completes after E33
    task automatic multi(input string nm, input logic [4:0] o, input logic [31:0] a, b, exp);
        int hi_cnt = 0;
        drive(o, a, b, 5'd12, 1'b1);
        tick();
        drive(`ALU_ADD, 32'd10, 32'd20, 5'd13, 1'b1);
        if (stall) hi_cnt++;
        chk({nm, " bubble tag"}, {31'b0, write_alu_result_tag_out}, 32'd0);
        chk({nm, " bubble rd"}, {27'b0, reg_write_out}, 32'd0);
        repeat (31) begin
            tick();
            if (stall) hi_cnt++;
        end
        tick();
        chk({nm, " stall cycles"}, hi_cnt, 32'd32);
        chk({nm, " stall end"}, {31'b0, stall}, 32'd0);
        chk({nm, " result"}, result, exp);
        chk({nm, " rd"}, {27'b0, reg_write_out}, 32'd12);
        chk({nm, " tag"}, {31'b0, write_alu_result_tag_out}, 32'd1);
        tick();
        chk({nm, " held add"}, result, 32'd30);
        chk({nm, " held rd"}, {27'b0, reg_write_out}, 32'd13);
        drive(`ALU_NOP, '0, '0, '0, 1'b0);
    endtask

    initial begin
        int tg_seen;
        vq.push_back('{`ALU_ADD,  32'hFFFFFFFF, 32'd2,        5'd5, 1'b1, 32'h00000001, 5'd5, 1'b1, 1'b0});
        vq.push_back('{`ALU_SUB,  32'd5,        32'd7,        5'd3, 1'b1, 32'hFFFFFFFE, 5'd3, 1'b1, 1'b0});
        vq.push_back('{`ALU_AND,  32'hF0,       32'h3C,       5'd1, 1'b1, 32'h00000030, 5'd1, 1'b1, 1'b0});
        vq.push_back('{`ALU_OR,   32'hF0,       32'h0F,       5'd2, 1'b1, 32'h000000FF, 5'd2, 1'b1, 1'b0});
        vq.push_back('{`ALU_XOR,  32'hFF,       32'h0F,       5'd4, 1'b1, 32'h000000F0, 5'd4, 1'b1, 1'b0});
        vq.push_back('{`ALU_SLL,  32'd1,        32'h3F,       5'd6, 1'b1, 32'h80000000, 5'd6, 1'b1, 1'b0});
        vq.push_back('{`ALU_SRL,  32'h80000000, 32'd4,        5'd7, 1'b1, 32'h08000000, 5'd7, 1'b1, 1'b0});
        vq.push_back('{`ALU_SRA,  32'h80000000, 32'd4,        5'd8, 1'b1, 32'hF8000000, 5'd8, 1'b1, 1'b0});
        vq.push_back('{`ALU_SLT,  32'hFFFFFFFF, 32'd1,        5'd9, 1'b1, 32'h00000001, 5'd9, 1'b1, 1'b0});
        vq.push_back('{`ALU_SLTU, 32'hFFFFFFFF, 32'd1,        5'd10, 1'b1, 32'h00000000, 5'd10, 1'b1, 1'b0});
        vq.push_back('{`ALU_ADD,  32'h7FFFFFFF, 32'd1,        5'd9, 1'b0, 32'h80000000, 5'd9, 1'b0, 1'b0});
        vq.push_back('{`ALU_NOP,  32'd3,        32'd4,        5'd7, 1'b1, 32'h80000000, 5'd0, 1'b0, 1'b0});
        vq.push_back('{5'd31,     32'd3,        32'd4,        5'd7, 1'b1, 32'h00000000, 5'd0, 1'b0, 1'b1});
`ifndef EX_DIV_EN
        vq.push_back('{`ALU_DIVU, 32'd10,       32'd3,        5'd2, 1'b1, 32'h00000000, 5'd0, 1'b0, 1'b1});
`endif
        vq.push_back('{`ALU_ADD,  32'd3,        32'd4,        5'd11, 1'b1, 32'h00000007, 5'd11, 1'b1, 1'b0});

        #2 rst = 1'b0;
        #1;
        chk("reset result", result, 32'd0);
        chk("reset rd", {27'b0, reg_write_out}, 32'd0);
        chk("reset tag", {31'b0, write_alu_result_tag_out}, 32'd0);
        chk("reset stall", {31'b0, stall}, 32'd0);
        chk("reset illegal", {31'b0, illegal_op}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();

        foreach (vq[i]) begin
            drive(vq[i].op, vq[i].a, vq[i].b, vq[i].rd, vq[i].tg);
            tick();
            chk($sformatf("vec%0d result", i), result, vq[i].er);
            chk($sformatf("vec%0d rd", i), {27'b0, reg_write_out}, {27'b0, vq[i].erd});
            chk($sformatf("vec%0d tag", i), {31'b0, write_alu_result_tag_out}, {31'b0, vq[i].etg});
            chk($sformatf("vec%0d illegal", i), {31'b0, illegal_op}, {31'b0, vq[i].eill});
            chk($sformatf("vec%0d stall", i), {31'b0, stall}, 32'd0);
        end
        drive(`ALU_NOP, '0, '0, '0, 1'b0);
        tick();

        multi("mul", `ALU_MUL, 32'h00010000, 32'h00030000, 32'h00000000);
        multi("mulhu", `ALU_MULHU, 32'h00010000, 32'h00030000, 32'h00000003);
        multi("mul_max", `ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        multi("mulhu_max", `ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
`ifdef EX_DIV_EN
        multi("div_neg", `ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        multi("rem_neg", `ALU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        multi("div_negdiv", `ALU_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD);
        multi("rem_negdiv", `ALU_REM, 32'd7, 32'hFFFFFFFE, 32'h00000001);
        multi("divu", `ALU_DIVU, 32'd100, 32'd7, 32'd14);
        multi("remu", `ALU_REMU, 32'd100, 32'd7, 32'd2);
        multi("divu_zero", `ALU_DIVU, 32'd10, 32'd0, 32'hFFFFFFFF);
        multi("div_zero", `ALU_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
        multi("rem_zero", `ALU_REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
        multi("div_ovf", `ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        multi("rem_ovf", `ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
`endif

        // flush sampled at the edge where cnt==10; SUB presented alongside is killed
        drive(`ALU_MUL, 32'd3, 32'd5, 5'd4, 1'b1);
        tick();
        repeat (10) tick();
        chk("flush pre stall", {31'b0, stall}, 32'd1);
        flush = 1'b1;
        drive(`ALU_SUB, 32'd5, 32'd7, 5'd6, 1'b1);
        tick();
        flush = 1'b0;
        chk("flush stall", {31'b0, stall}, 32'd0);
        chk("flush tag", {31'b0, write_alu_result_tag_out}, 32'd0);
        chk("flush rd", {27'b0, reg_write_out}, 32'd0);
        tick();
        chk("post flush sub", result, 32'hFFFFFFFE);
        chk("post flush sub rd", {27'b0, reg_write_out}, 32'd6);
        drive(`ALU_NOP, '0, '0, '0, 1'b0);
        tg_seen = 0;
        repeat (25) begin
            tick();
            if (write_alu_result_tag_out || stall) tg_seen++;
        end
        chk("flush no late result", tg_seen, 32'd0);

        // asynchronous reset in the middle of an iterative op
`ifdef EX_DIV_EN
        drive(`ALU_DIV, 32'd100, 32'd7, 5'd9, 1'b1);
`else
        drive(`ALU_MUL, 32'd100, 32'd7, 5'd9, 1'b1);
`endif
        tick();
        repeat (5) tick();
        chk("pre reset stall", {31'b0, stall}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async reset result", result, 32'd0);
        chk("async reset stall", {31'b0, stall}, 32'd0);
        chk("async reset rd", {27'b0, reg_write_out}, 32'd0);
        chk("async reset tag", {31'b0, write_alu_result_tag_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(`ALU_AND, 32'hF0, 32'h3C, 5'd3, 1'b1);
        tick();
        chk("post reset and", result, 32'h30);
        chk("post reset tag", {31'b0, write_alu_result_tag_out}, 32'd1);
        chk("post reset stall", {31'b0, stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
